// File: rtl/datapath_param.sv
// Parameterised register-file datapath: 1-cycle ALU, WIDTH-cycle shift-add MUL, PC/LR.
// Define DATAPATH_SCAN_EN to add the ScanEnable/ScanIn/ScanOut register-file chain.
module datapath_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS),
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             nReset,
`ifdef DATAPATH_SCAN_EN
  input  logic             ScanEnable,
  input  logic             ScanIn,
  output logic             ScanOut,
`endif
  input  logic             Issue,
  input  logic [3:0]       Op,
  input  logic [AW-1:0]    Rs1,
  input  logic [AW-1:0]    Rs2,
  input  logic [AW-1:0]    Rw,
  input  logic             Op2Sel,
  input  logic [WIDTH-1:0] Imm,
  input  logic             WdSel,
  input  logic [WIDTH-1:0] SysBusIn,
  input  logic             We,
  input  logic             CIn,
  input  logic             PcWe,
  input  logic [1:0]       PcSel,
  input  logic             LrWe,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Pc,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ASR  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_PB   = 4'hD;
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  logic [WIDTH-1:0]   rf [NREGS];
  logic [WIDTH-1:0]   lr;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   alu_val;
  logic [WIDTH-1:0]   rorv;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   pc_inc;
  logic               alu_c;
  logic               alu_v;
  logic [SW-1:0]      sh;
  logic [SW:0]        rsh;
  logic [WIDTH:0]     addw;
  logic [WIDTH:0]     subw;
  logic [WIDTH:0]     shlw;
  logic [WIDTH:0]     shrw;
  logic [WIDTH:0]     asrw;
  logic [2*WIDTH-1:0] m_acc;
  logic [2*WIDTH-1:0] m_cand;
  logic [2*WIDTH-1:0] m_next;
  logic [WIDTH-1:0]   m_plier;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;
  logic [SW-1:0]      m_cnt;
  logic [AW-1:0]      m_rw;
  logic               m_we;
  logic               m_wds;
  logic               m_last;
  logic               accept;
  logic               fn_ok;

`ifdef DATAPATH_SCAN_EN
  assign fn_ok   = ~Busy & ~ScanEnable;
  assign ScanOut = rf[NREGS-1][WIDTH-1];
`else
  assign fn_ok   = ~Busy;
`endif

  assign accept = Issue & fn_ok;
  assign opa    = rf[Rs1];
  assign opb    = Op2Sel ? Imm : rf[Rs2];
  assign sh     = opb[SW-1:0];
  assign pc_inc = Pc + WIDTH'(1);
  assign m_next = m_acc + (m_plier[0] ? m_cand : '0);
  assign mul_lo = m_next[WIDTH-1:0];
  assign mul_hi = m_next[2*WIDTH-1:WIDTH];
  assign m_last = Busy & (m_cnt == CNT_LAST);
  assign wd     = WdSel ? SysBusIn : alu_val;

  always_comb begin
    addw  = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, CIn};
    subw  = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
    shlw  = {1'b0, opa} << sh;
    shrw  = {opa, 1'b0} >> sh;
    asrw  = $signed({opa, 1'b0}) >>> sh;
    rsh   = (SW+1)'(WIDTH) - {1'b0, sh};
    rorv  = (opa >> sh) | (opa << rsh);
    alu_val = opa;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_val = addw[WIDTH-1:0];
        alu_c   = addw[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                  (addw[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_val = subw[WIDTH-1:0];
        alu_c   = subw[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                  (subw[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:  alu_val = opa & opb;
      OP_OR:   alu_val = opa | opb;
      OP_XOR:  alu_val = opa ^ opb;
      OP_NOT:  alu_val = ~opa;
      OP_NAND: alu_val = ~(opa & opb);
      OP_NOR:  alu_val = ~(opa | opb);
      OP_SHL: begin
        alu_val = shlw[WIDTH-1:0];
        alu_c   = shlw[WIDTH];
      end
      OP_SHR: begin
        alu_val = shrw[WIDTH:1];
        alu_c   = shrw[0];
      end
      OP_ASR: begin
        alu_val = asrw[WIDTH:1];
        alu_c   = asrw[0];
      end
      // last bit rotated out lands in the MSB
      OP_ROR: begin
        alu_val = rorv;
        alu_c   = (sh != '0) & rorv[WIDTH-1];
      end
      OP_PB:   alu_val = opb;
      default: alu_val = opa;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
`ifdef DATAPATH_SCAN_EN
    end else if (ScanEnable) begin
      rf[0] <= {rf[0][WIDTH-2:0], ScanIn};
      for (int i = 1; i < NREGS; i++)
        rf[i] <= {rf[i][WIDTH-2:0], rf[i-1][WIDTH-1]};
`endif
    end else if (accept && Op != OP_MUL && We) begin
      rf[Rw] <= wd;
    end else if (m_last && m_we) begin
      rf[m_rw] <= m_wds ? SysBusIn : mul_lo;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      m_acc   <= '0;
      m_cand  <= '0;
      m_plier <= '0;
      m_cnt   <= '0;
      m_rw    <= '0;
      m_we    <= 1'b0;
      m_wds   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept && Op == OP_MUL) begin
        Busy    <= 1'b1;
        m_acc   <= '0;
        m_cand  <= {{WIDTH{1'b0}}, opa};
        m_plier <= opb;
        m_cnt   <= '0;
        m_rw    <= Rw;
        m_we    <= We;
        m_wds   <= WdSel;
      end else if (Busy) begin
        if (m_cnt == CNT_LAST) begin
          Busy <= 1'b0;
          Done <= 1'b1;
        end else begin
          m_acc   <= m_next;
          m_cand  <= m_cand << 1;
          m_plier <= m_plier >> 1;
          m_cnt   <= m_cnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Result <= '0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else if (accept && Op != OP_MUL) begin
      Result <= alu_val;
      Z      <= (alu_val == '0);
      N      <= alu_val[WIDTH-1];
      C      <= alu_c;
      V      <= alu_v;
    end else if (m_last) begin
      Result <= mul_lo;
      Z      <= (mul_lo == '0);
      N      <= mul_lo[WIDTH-1];
      C      <= |mul_hi;
      V      <= 1'b0;
    end
  end

  // LR samples the pre-edge Pc+1, so LrWe+PcWe together behave as a call
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Pc <= '0;
      lr <= '0;
    end else if (fn_ok) begin
      if (LrWe) lr <= pc_inc;
      if (PcWe) begin
        case (PcSel)
          2'b01:   Pc <= pc_inc;
          2'b10:   Pc <= alu_val;
          2'b11:   Pc <= lr;
          default: Pc <= Pc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Scoreboard bench for datapath_param: queued expectations from a behavioural
// model, popped by a monitor on each completed operation.
module tb_datapath_param;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Issue;
  logic [3:0]  Op;
  logic [2:0]  Rs1, Rs2, Rw;
  logic        Op2Sel;
  logic [15:0] Imm;
  logic        WdSel;
  logic [15:0] SysBusIn;
  logic        We, CIn, PcWe, LrWe;
  logic [1:0]  PcSel;
  logic [15:0] Result, Pc;
  logic        Z, N, C, V, Busy, Done;

  datapath_param #(.WIDTH(16), .NREGS(8)) dut (
    .Clock(Clock), .nReset(nReset), .Issue(Issue), .Op(Op),
    .Rs1(Rs1), .Rs2(Rs2), .Rw(Rw), .Op2Sel(Op2Sel), .Imm(Imm),
    .WdSel(WdSel), .SysBusIn(SysBusIn), .We(We), .CIn(CIn),
    .PcWe(PcWe), .PcSel(PcSel), .LrWe(LrWe), .Result(Result),
    .Pc(Pc), .Z(Z), .N(N), .C(C), .V(V), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
  } alu_t;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    bit          chk_res;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          tag = 0;
  int          done_cnt = 0;
  logic [15:0] mr[8];
  logic [15:0] mpc, mlr;
  logic        fire_in = 1'b0;
  logic        fire = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic alu_t ref_op(logic [3:0] op, logic [15:0] a,
                                  logic [15:0] b, logic cin);
    int ua, ub, sa, sb2, s, sh;
    longint p;
    alu_t o;
    ua = int'(a);
    ub = int'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb2 = b[15] ? ub - 65536 : ub;
    sh = ub % 16;
    o = '0;
    case (op)
      0: begin
        s = ua + ub + int'(cin);
        o.r = s[15:0];
        o.c = s > 65535;
        o.v = (sa + sb2 + int'(cin) > 32767) || (sa + sb2 + int'(cin) < -32768);
      end
      1: begin
        s = ua - ub;
        o.r = s[15:0];
        o.c = ua >= ub;
        o.v = (sa - sb2 > 32767) || (sa - sb2 < -32768);
      end
      2: o.r = a & b;
      3: o.r = a | b;
      4: o.r = a ^ b;
      5: o.r = ~a;
      6: o.r = ~(a & b);
      7: o.r = ~(a | b);
      8: begin
        s = ua << sh;
        o.r = s[15:0];
        o.c = s[16];
      end
      9: begin
        o.r = 16'(ua >> sh);
        if (sh != 0) o.c = ((ua >> (sh - 1)) & 1) != 0;
      end
      10: begin
        s = sa >>> sh;
        o.r = s[15:0];
        if (sh != 0) o.c = ((sa >>> (sh - 1)) & 1) != 0;
      end
      11: begin
        o.r = 16'((ua >> sh) | (ua << (16 - sh)));
        if (sh != 0) o.c = ((ua >> (sh - 1)) & 1) != 0;
      end
      12: begin
        p = longint'(ua) * longint'(ub);
        o.r = p[15:0];
        o.c = p[31:16] != 0;
      end
      13: o.r = b;
      default: o.r = a;
    endcase
    return o;
  endfunction

  function automatic exp_t mk(alu_t r, bit chk, int t);
    exp_t e;
    e.r = r.r;
    e.f = {r.r == 16'h0, r.r[15], r.c, r.v};
    e.chk_res = chk;
    e.tag = t;
    return e;
  endfunction

  task automatic pc_model(logic pcwe, logic [1:0] pcsel, logic lrwe,
                          logic [15:0] alu);
    logic [15:0] old_lr;
    old_lr = mlr;
    if (lrwe) mlr = mpc + 16'd1;
    if (pcwe) begin
      case (pcsel)
        2'd1: mpc = mpc + 16'd1;
        2'd2: mpc = alu;
        2'd3: mpc = old_lr;
        default: ;
      endcase
    end
  endtask

  always @(posedge Clock) fire <= fire_in;

  always @(posedge Clock) if (nReset && Done) done_cnt++;

  always @(negedge Clock) begin
    if (nReset && (fire || Done)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: Result %h with empty scoreboard", Result);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_res)
          check($sformatf("result#%0d", mon_e.tag), Result, mon_e.r);
        check($sformatf("flags_zncv#%0d", mon_e.tag), {Z, N, C, V}, mon_e.f);
      end
    end
  end

  task automatic clear_in();
    Issue = 0; Op = 0; Rs1 = 0; Rs2 = 0; Rw = 0; Op2Sel = 0; Imm = 0;
    WdSel = 0; SysBusIn = 0; We = 0; CIn = 0; PcWe = 0; PcSel = 0;
    LrWe = 0; fire_in = 0;
  endtask

  task automatic op1(logic [3:0] op, logic [2:0] rs1, logic [2:0] rs2,
                     logic [2:0] rw, logic o2s, logic [15:0] imm, logic we,
                     logic wds, logic [15:0] bus, logic cin, logic pcwe,
                     logic [1:0] pcsel, logic lrwe);
    alu_t r;
    r = ref_op(op, mr[rs1], o2s ? imm : mr[rs2], cin);
    tag++;
    sb.push_back(mk(r, !wds, tag));
    Op = op; Rs1 = rs1; Rs2 = rs2; Rw = rw; Op2Sel = o2s; Imm = imm;
    We = we; WdSel = wds; SysBusIn = bus; CIn = cin;
    PcWe = pcwe; PcSel = pcsel; LrWe = lrwe;
    Issue = 1; fire_in = 1;
    @(posedge Clock); #1;
    if (we) mr[rw] = wds ? bus : r.r;
    pc_model(pcwe, pcsel, lrwe, r.r);
    clear_in();
    check($sformatf("pc#%0d", tag), Pc, mpc);
  endtask

  task automatic ld(logic [2:0] rw, logic [15:0] v);
    op1(4'hD, 0, 0, rw, 1, v, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pc_step(logic pcwe, logic [1:0] pcsel, logic lrwe);
    PcWe = pcwe; PcSel = pcsel; LrWe = lrwe;
    @(posedge Clock); #1;
    pc_model(pcwe, pcsel, lrwe, 16'h0);
    clear_in();
    check("pc_step", Pc, mpc);
  endtask

  task automatic mul(logic [2:0] rs1, logic [2:0] rs2, logic o2s,
                     logic [15:0] imm, logic [2:0] rw, logic we, logic wds,
                     logic [15:0] bus);
    alu_t r;
    int k;
    bit got;
    r = ref_op(4'hC, mr[rs1], o2s ? imm : mr[rs2], 0);
    tag++;
    sb.push_back(mk(r, !wds, tag));
    Op = 4'hC; Rs1 = rs1; Rs2 = rs2; Op2Sel = o2s; Imm = imm; Rw = rw;
    We = we; WdSel = wds; SysBusIn = bus; Issue = 1;
    @(posedge Clock); #1;
    check("busy_after_accept", Busy, 1);
    k = 0;
    got = 0;
    while (k < 40 && !got) begin
      Issue = 1; Op = 4'($urandom_range(0, 11)); Rs1 = 3'($urandom);
      Rs2 = 3'($urandom); Rw = 3'($urandom); Imm = 16'($urandom);
      We = 1; PcWe = 1; PcSel = 2'($urandom); LrWe = 1;
      @(posedge Clock); #1;
      k++;
      if (Done) got = 1;
    end
    clear_in();
    check("mul_busy_cycles", k, 16);
    check("busy_after_done", Busy, 0);
    check("pc_frozen_during_mul", Pc, mpc);
    if (we) mr[rw] = wds ? bus : r.r;
  endtask

  initial begin
    clear_in();
    nReset = 0;
    for (int i = 0; i < 8; i++) mr[i] = 0;
    mpc = 0;
    mlr = 0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_result", Result, 0);
    check("reset_pc", Pc, 0);
    check("reset_flags", {Z, N, C, V, Busy, Done}, 0);
    nReset = 1;
    @(posedge Clock); #1;

    ld(1, 16'h7FFF);
    ld(2, 16'h0001);
    op1(4'h0, 1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("add_ovf_flags", {Z, N, C, V}, 4'b0101);
    op1(4'hE, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("add_ovf_r3", Result, 16'h8000);

    ld(1, 16'h0005);
    op1(4'h1, 1, 0, 0, 1, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    check("sub_zero", {Result, Z, C}, {16'h0, 1'b1, 1'b1});

    ld(1, 16'h8001);
    op1(4'hA, 1, 0, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    check("asr", {Result, C}, {16'hC000, 1'b1});
    op1(4'hB, 1, 0, 0, 1, 16'h0004, 0, 0, 0, 0, 0, 0, 0);
    check("ror", Result, 16'h1800);

    ld(4, 16'h0102);
    mul(4, 0, 1, 16'h0003, 5, 1, 0, 0);
    check("mul_c0", {Result, C}, {16'h0306, 1'b0});
    op1(4'hE, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mul_r5", Result, 16'h0306);
    ld(4, 16'h8000);
    mul(4, 0, 1, 16'h0002, 5, 1, 0, 0);
    check("mul_wrap", {Result, Z, C}, {16'h0, 1'b1, 1'b1});

    op1(4'hD, 0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 1, 2, 0);
    check("pc_load_alu", Pc, 16'hFFFF);
    pc_step(1, 1, 1);
    check("pc_wrap", Pc, 16'h0000);
    pc_step(1, 1, 0);
    pc_step(1, 3, 0);
    check("pc_from_lr", Pc, 16'h0000);

    op1(4'h0, 1, 2, 7, 0, 0, 1, 1, 16'hBEEF, 0, 0, 0, 0);
    op1(4'hE, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wdsel_bus", Result, 16'hBEEF);

    for (int it = 0; it < 150; it++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hC)
        mul(3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            16'($urandom));
      else
        op1(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
            16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom));
    end

    ld(6, 16'h1234);
    Op = 4'hC; Rs1 = 6; Op2Sel = 1; Imm = 16'h0003; Rw = 6; We = 1;
    Issue = 1;
    @(posedge Clock); #1;
    clear_in();
    repeat (5) @(posedge Clock);
    #1;
    nReset = 0;
    #1;
    check("abort_busy_done", {Busy, Done}, 2'b00);
    check("abort_result_pc", {Result, Pc}, 32'h0);
    for (int i = 0; i < 8; i++) mr[i] = 0;
    mpc = 0;
    mlr = 0;
    done_cnt = 0;
    @(posedge Clock); #1;
    nReset = 1;
    repeat (20) @(posedge Clock);
    #1;
    check("abort_no_done", done_cnt, 0);
    op1(4'hE, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("abort_target_zero", Result, 16'h0);

    repeat (3) @(posedge Clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
